// File: rtl/rotate_pingpong_ctrl.sv
// Bank scheduler for the two-RAM rotation buffer: ping-pongs line-block banks between writer and reader.
// Optional ROTATE_PINGPONG_STATS_EN macro enables the saturating dropped_rows counter.
module rotate_pingpong_ctrl #(
    parameter int BLOCK_ROWS = 8,
    parameter int CNT_W      = 8
) (
    input  logic             img_clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             frame_start,
    input  logic             frame_end,
    input  logic             row_done,
    input  logic             rd_done,
    output logic             wr_ready,
    output logic             wr_bank,
    output logic             rd_start,
    output logic             rd_bank,
    output logic [CNT_W-1:0] rd_rows,
    output logic             overflow,
    output logic [15:0]      dropped_rows,
    output logic [3:0]       bank_state
);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_t;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BLOCK_ROWS);

    bank_st_t         st    [2];
    bank_st_t         st_n  [2];
    logic [CNT_W-1:0] cnt   [2];
    logic [CNT_W-1:0] cnt_n [2];
    logic             frame_active, active_n;
    logic             wr_bank_n, rd_bank_n;
    logic             wr_ready_n, rd_start_n, overflow_n;
    logic [CNT_W-1:0] rd_rows_n;

    // Writer side is resolved first (row count, then frame_end, then frame_start);
    // reader side only ever touches FULL/DRAINING banks so the two never collide.
    always_comb begin
        st_n       = st;
        cnt_n      = cnt;
        wr_bank_n  = wr_bank;
        rd_bank_n  = rd_bank;
        active_n   = frame_active;
        overflow_n = overflow;
        rd_start_n = 1'b0;
        rd_rows_n  = rd_rows;

        if (st[wr_bank] == EMPTY && frame_active && enable)
            st_n[wr_bank] = FILLING;

        if (row_done) begin
            if (wr_ready) begin
                cnt_n[wr_bank] = cnt[wr_bank] + 1'b1;
                if (cnt_n[wr_bank] == FULL_CNT) begin
                    st_n[wr_bank] = FULL;
                    wr_bank_n     = ~wr_bank;
                end
            end else begin
                overflow_n = 1'b1;
            end
        end

        if (frame_end) begin
            active_n = 1'b0;
            if (st_n[wr_bank_n] == FILLING) begin
                if (cnt_n[wr_bank_n] != '0) begin
                    st_n[wr_bank_n] = FULL;
                    wr_bank_n       = ~wr_bank_n;
                end else begin
                    st_n[wr_bank_n] = EMPTY;
                end
            end
        end

        if (frame_start && enable) begin
            if (frame_active && st_n[wr_bank_n] == FILLING) begin
                st_n[wr_bank_n]  = EMPTY;
                cnt_n[wr_bank_n] = '0;
            end
            active_n   = 1'b1;
            overflow_n = 1'b0;
        end

        if (st[0] != DRAINING && st[1] != DRAINING && st[rd_bank] == FULL) begin
            st_n[rd_bank] = DRAINING;
            rd_rows_n     = cnt[rd_bank];
            rd_start_n    = 1'b1;
        end else if (rd_done && st[rd_bank] == DRAINING) begin
            st_n[rd_bank]  = EMPTY;
            cnt_n[rd_bank] = '0;
            rd_bank_n      = ~rd_bank;
        end

        wr_ready_n = (st_n[wr_bank_n] == FILLING);
    end

    always_ff @(posedge img_clk) begin
        if (reset) begin
            st[0]        <= EMPTY;
            st[1]        <= EMPTY;
            cnt[0]       <= '0;
            cnt[1]       <= '0;
            frame_active <= 1'b0;
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b0;
            wr_ready     <= 1'b0;
            rd_start     <= 1'b0;
            rd_rows      <= '0;
            overflow     <= 1'b0;
        end else begin
            st[0]        <= st_n[0];
            st[1]        <= st_n[1];
            cnt[0]       <= cnt_n[0];
            cnt[1]       <= cnt_n[1];
            frame_active <= active_n;
            wr_bank      <= wr_bank_n;
            rd_bank      <= rd_bank_n;
            wr_ready     <= wr_ready_n;
            rd_start     <= rd_start_n;
            rd_rows      <= rd_rows_n;
            overflow     <= overflow_n;
        end
    end

`ifdef ROTATE_PINGPONG_STATS_EN
    logic drop;
    assign drop = row_done & ~wr_ready;

    always_ff @(posedge img_clk) begin
        if (reset)
            dropped_rows <= '0;
        else if (drop && dropped_rows != 16'hFFFF)
            dropped_rows <= dropped_rows + 16'd1;
    end
`else
    assign dropped_rows = '0;
`endif

    assign bank_state = {st[1], st[0]};

endmodule

// File: tb/tb_rotate_pingpong_ctrl.sv
// Bench for rotate_pingpong_ctrl: queue-based bank model checked every cycle,
// directed scenarios with literal expectations, then a randomised pulse phase.
module tb_rotate_pingpong_ctrl;

    localparam int BR    = 8;
    localparam int CNT_W = 8;

    logic             img_clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic             frame_start = 1'b0;
    logic             frame_end = 1'b0;
    logic             row_done = 1'b0;
    logic             rd_done = 1'b0;
    logic             wr_ready, wr_bank, rd_start, rd_bank, overflow;
    logic [CNT_W-1:0] rd_rows;
    logic [15:0]      dropped_rows;
    logic [3:0]       bank_state;

    always #5 img_clk = ~img_clk;

    rotate_pingpong_ctrl #(.BLOCK_ROWS(BR), .CNT_W(CNT_W)) dut (
        .img_clk(img_clk), .reset(reset), .enable(enable),
        .frame_start(frame_start), .frame_end(frame_end),
        .row_done(row_done), .rd_done(rd_done),
        .wr_ready(wr_ready), .wr_bank(wr_bank), .rd_start(rd_start),
        .rd_bank(rd_bank), .rd_rows(rd_rows), .overflow(overflow),
        .dropped_rows(dropped_rows), .bank_state(bank_state)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: blocks are tracked in fill order; a bank is just "the next one"
    // because fills and drains both alternate.
    bit m_active, m_filling, m_draining, m_wr_bank, m_rd_bank, m_rd_start, m_overflow;
    int m_cnt, m_rd_rows, m_dropped;
    int ready_q[$];

    always @(posedge img_clk) begin : model
        int  occ;
        bit  had_fill, had_drain, had_active;
        if (reset) begin
            m_active = 0; m_filling = 0; m_draining = 0; m_wr_bank = 0; m_rd_bank = 0;
            m_rd_start = 0; m_overflow = 0; m_cnt = 0; m_rd_rows = 0; m_dropped = 0;
            ready_q.delete();
        end else begin
            occ        = ready_q.size() + int'(m_draining);
            had_fill   = m_filling;
            had_drain  = m_draining;
            had_active = m_active;
            m_rd_start = 0;
            if (!had_drain && ready_q.size() > 0) begin
                m_rd_rows  = ready_q.pop_front();
                m_draining = 1;
                m_rd_start = 1;
            end else if (had_drain && rd_done) begin
                m_draining = 0;
                m_rd_bank  = ~m_rd_bank;
            end
            if (!had_fill && occ < 2 && had_active && enable) begin
                m_filling = 1;
                m_cnt     = 0;
            end
            if (row_done) begin
                if (had_fill) begin
                    m_cnt++;
                    if (m_cnt == BR) begin
                        ready_q.push_back(m_cnt);
                        m_filling = 0; m_cnt = 0; m_wr_bank = ~m_wr_bank;
                    end
                end else begin
                    m_overflow = 1;
                    if (m_dropped < 65535) m_dropped++;
                end
            end
            if (frame_end) begin
                m_active = 0;
                if (m_filling) begin
                    if (m_cnt > 0) begin
                        ready_q.push_back(m_cnt);
                        m_wr_bank = ~m_wr_bank;
                    end
                    m_filling = 0; m_cnt = 0;
                end
            end
            if (frame_start && enable) begin
                if (had_active && m_filling) begin
                    m_filling = 0; m_cnt = 0;
                end
                m_active   = 1;
                m_overflow = 0;
            end
        end
    end

    function automatic int exp_dropped();
`ifdef ROTATE_PINGPONG_STATS_EN
        return m_dropped;
`else
        return 0;
`endif
    endfunction

    always @(negedge img_clk) begin : compare
        check("m_wr_ready", wr_ready, m_filling);
        check("m_wr_bank", wr_bank, m_wr_bank);
        check("m_rd_start", rd_start, m_rd_start);
        check("m_rd_bank", rd_bank, m_rd_bank);
        check("m_rd_rows", rd_rows, m_rd_rows);
        check("m_overflow", overflow, m_overflow);
        check("m_dropped", dropped_rows, exp_dropped());
    end

    task automatic drive(input bit fs, input bit fe, input bit rw, input bit rdd);
        frame_start = fs; frame_end = fe; row_done = rw; rd_done = rdd;
        @(negedge img_clk);
        frame_start = 0; frame_end = 0; row_done = 0; rd_done = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0);
    endtask

    task automatic rows(input int n);
        repeat (n) drive(0, 0, 1, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_ready"}, wr_ready, 0);
        check({tag, "_wr_bank"}, wr_bank, 0);
        check({tag, "_rd_start"}, rd_start, 0);
        check({tag, "_rd_bank"}, rd_bank, 0);
        check({tag, "_rd_rows"}, rd_rows, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_dropped"}, dropped_rows, 0);
    endtask

    initial begin
        repeat (2) @(negedge img_clk);
        check_all_zero("reset");
        reset = 0; enable = 1;

        // fill bank0, reader gets it one clock after FULL
        drive(1, 0, 0, 0);
        check("t1_no_ready_yet", wr_ready, 0);
        idle(1);
        check("t1_ready", wr_ready, 1);
        rows(8);
        check("t1_wr_bank", wr_bank, 1);
        check("t1_ready_drop", wr_ready, 0);
        check("t1_no_start", rd_start, 0);
        idle(1);
        check("t1_rd_start", rd_start, 1);
        check("t1_rd_bank", rd_bank, 0);
        check("t1_rd_rows", rd_rows, 8);
        check("t1_ready_b1", wr_ready, 1);

        // both banks busy -> drops
        rows(8);
        check("t2_stall", wr_ready, 0);
        check("t2_wr_bank", wr_bank, 0);
        rows(3);
        check("t2_overflow", overflow, 1);
`ifdef ROTATE_PINGPONG_STATS_EN
        check("t2_dropped", dropped_rows, 3);
`else
        check("t2_dropped", dropped_rows, 0);
`endif
        drive(0, 0, 0, 1);
        check("t2_rd_bank", rd_bank, 1);
        idle(1);
        check("t2_rd_start", rd_start, 1);
        check("t2_rd_rows", rd_rows, 8);
        check("t2_refill", wr_ready, 1);

        // fill-complete and rd_done on the same edge
        rows(7);
        drive(0, 0, 1, 1);
        check("t4_wr_bank", wr_bank, 1);
        check("t4_rd_bank", rd_bank, 0);
        check("t4_no_start", rd_start, 0);
        idle(1);
        check("t4_rd_start", rd_start, 1);
        check("t4_refill", wr_ready, 1);

        // frame_start discards the partial FILLING bank
        rows(3);
        check("t5_ovf_sticky", overflow, 1);
        drive(1, 0, 0, 0);
        check("t5_ovf_clear", overflow, 0);
        check("t5_discard", wr_ready, 0);
        drive(0, 0, 0, 1);
        check("t5_rd_done", rd_bank, 1);
        check("t5_refill", wr_ready, 1);

        // partial block on frame_end, then empty frame
        rows(5);
        drive(0, 1, 0, 0);
        check("t3_wr_bank", wr_bank, 0);
        idle(1);
        check("t3_rd_start", rd_start, 1);
        check("t3_rd_rows", rd_rows, 5);
        drive(0, 0, 0, 1);
        drive(1, 0, 0, 0);
        idle(1);
        check("t3_fill", wr_ready, 1);
        drive(0, 1, 0, 0);
        idle(3);
        check("t3_empty_wr_bank", wr_bank, 0);
        check("t3_empty_no_start", rd_start, 0);

        // enable gating
        enable = 0;
        drive(1, 0, 0, 0);
        idle(2);
        check("en_ignored", wr_ready, 0);
        enable = 1;
        drive(1, 0, 0, 0);
        idle(1);
        rows(2);
        enable = 0;
        idle(2);
        check("en_hold_fill", wr_ready, 1);
        drive(0, 1, 0, 0);
        idle(1);
        check("en_rd_rows", rd_rows, 2);
        drive(0, 0, 0, 1);
        enable = 1;

        // reset mid-drain
        drive(1, 0, 0, 0);
        idle(1);
        rows(8);
        idle(1);
        check("t6_draining", rd_start, 1);
        reset = 1;
        @(negedge img_clk);
        check_all_zero("t6_reset");
        reset = 0;
        drive(0, 0, 0, 1);
        check("t6_rd_ignored", rd_bank, 0);
        idle(3);

        // randomised pulse mix, checked by the model every cycle
        for (int i = 0; i < 400; i++) begin
            bit fs, fe, rw, rdd;
            fs  = ($urandom_range(0, 40) == 0);
            fe  = !fs && ($urandom_range(0, 30) == 0);
            rw  = !fs && ($urandom_range(0, 1) == 1);
            rdd = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 60) == 0) enable = ~enable;
            drive(fs, fe, rw, rdd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
